// File: rtl/fetch_queue.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : fetch_queue                                               |
// | Purpose  : Instruction prefetch queue with 1-cycle memory and        |
// |            branch redirect flush.                                    |
// | Revision : 1.0 - initial release                                     |
// +----------------------------------------------------------------------+
module fetch_queue #(
  parameter int                DATA_W   = 16,
  parameter int                ADDR_W   = 16,
  parameter int                DEPTH    = 4,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic              clk,
  input  logic              rst,
  output logic              iReq,
  output logic [ADDR_W-1:0] iAddr,
  input  logic [DATA_W-1:0] dIn,
  input  logic              brTaken,
  input  logic [ADDR_W-1:0] brTarget,
  output logic              fValid,
  output logic [DATA_W-1:0] fInst,
  output logic [ADDR_W-1:0] fPc,
  input  logic              fReady
);

  localparam int                c_PTR_W = $clog2(DEPTH);
  localparam int                c_CNT_W = c_PTR_W + 1;
  localparam logic [c_CNT_W-1:0] c_FULL  = c_CNT_W'(DEPTH);
  localparam logic [c_CNT_W:0]   c_DEPTH = (c_CNT_W + 1)'(DEPTH);

  logic [ADDR_W-1:0]  r_pc;
  logic [c_CNT_W-1:0] r_count;
  logic [c_PTR_W-1:0] r_rdPtr;
  logic [c_PTR_W-1:0] r_wrPtr;
  logic               r_inflight;
  logic [ADDR_W-1:0]  r_inflightAddr;
  logic [ADDR_W-1:0]  r_addrMem [DEPTH];
  logic [DATA_W-1:0]  r_instMem [DEPTH];

  logic [c_CNT_W:0]   w_occupied;
  logic               w_req;
  logic               w_push;
  logic               w_pop;

  // Outstanding request reserves a slot so its response can never overflow.
  assign w_occupied = {1'b0, r_count} + {{c_CNT_W{1'b0}}, r_inflight};
  assign w_req      = !rst && !brTaken && (w_occupied < c_DEPTH);
  assign w_push     = r_inflight && !brTaken;
  assign w_pop      = fValid && fReady;

  assign iReq   = w_req;
  assign iAddr  = r_pc;
  assign fValid = !rst && (r_count != '0);
  assign fInst  = r_instMem[r_rdPtr];
  assign fPc    = r_addrMem[r_rdPtr];

  always_ff @(posedge clk) begin
    if (rst) begin
      r_pc       <= RESET_PC;
      r_count    <= '0;
      r_rdPtr    <= '0;
      r_wrPtr    <= '0;
      r_inflight <= 1'b0;
    end else if (brTaken) begin
      r_pc       <= brTarget;
      r_count    <= '0;
      r_rdPtr    <= '0;
      r_wrPtr    <= '0;
      r_inflight <= 1'b0;
    end else begin
      r_inflight <= w_req;
      if (w_req) begin
        r_pc           <= r_pc + 1'b1;
        r_inflightAddr <= r_pc;
      end
      if (w_push) begin
        r_addrMem[r_wrPtr] <= r_inflightAddr;
        r_instMem[r_wrPtr] <= dIn;
        r_wrPtr            <= r_wrPtr + 1'b1;
      end
      if (w_pop) begin
        r_rdPtr <= r_rdPtr + 1'b1;
      end
      if (w_push && !w_pop) begin
        r_count <= r_count + 1'b1;
      end else if (w_pop && !w_push) begin
        r_count <= r_count - 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst && !brTaken) begin
      assert (!(w_push && !w_pop && r_count == c_FULL));
    end
  end

endmodule
`default_nettype wire
